// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: streams words into imem from address 0,
// holds the core in reset during the load and releases it after a fixed delay.
module imem_loader #(
  parameter int ADDR_WIDTH  = 6,
  parameter int DATA_WIDTH  = 32,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   prog_len,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [DATA_WIDTH-1:0] imem_wdata,
  output logic                  cpu_reset,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH:0]   word_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_HOLD,
    S_RUN
  } state_e;

  localparam logic [ADDR_WIDTH:0] DEPTH =
    {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic [7:0]            hold_q, hold_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  cpu_rst_q, cpu_rst_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic                  len_ok;
  logic                  beat;
  logic [ADDR_WIDTH:0]   cnt_inc;

  assign len_ok  = (prog_len != '0) && (prog_len <= DEPTH);
  assign beat    = s_valid && (state_q == S_LOAD);
  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    hold_d    = hold_q;
    we_d      = 1'b0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cpu_rst_d = cpu_rst_q;
    busy_d    = busy_q;
    done_d    = done_q;
    err_d     = err_q;
    unique case (state_q)
      S_IDLE, S_RUN: begin
        // RUN restarts exactly like IDLE; an illegal start leaves the core running.
        if (start) begin
          if (len_ok) begin
            state_d   = S_LOAD;
            len_d     = prog_len;
            cnt_d     = '0;
            err_d     = 1'b0;
            busy_d    = 1'b1;
            done_d    = 1'b0;
            cpu_rst_d = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (beat) begin
          we_d    = 1'b1;
          addr_d  = cnt_q[ADDR_WIDTH-1:0];
          wdata_d = s_data;
          cnt_d   = cnt_inc;
          if (cnt_inc == len_q) begin
            state_d = S_HOLD;
            hold_d  = '0;
          end
        end
      end
      S_HOLD: begin
        if (hold_q == HOLD_LAST) begin
          state_d   = S_RUN;
          cpu_rst_d = 1'b1;
          busy_d    = 1'b0;
          done_d    = 1'b1;
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      cnt_q     <= '0;
      hold_q    <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cpu_rst_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cpu_rst_q <= cpu_rst_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign s_ready    = (state_q == S_LOAD);
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_reset  = cpu_rst_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign word_cnt   = cnt_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: edge-level behavioural model plus directed loads,
// gapped streams, illegal lengths, full-depth fill and mid-load reset.
module tb_imem_loader;

  localparam int AW = 6;
  localparam int DW = 32;
  localparam int HC = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW:0]   prog_len;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_wdata;
  logic          cpu_reset;
  logic          busy;
  logic          done;
  logic          err;
  logic [AW:0]   word_cnt;

  imem_loader #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .HOLD_CYCLES(HC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .prog_len  (prog_len),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .cpu_reset (cpu_reset),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .word_cnt  (word_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Model: "loading" holds until the n-th accepted word; the core is then
  // released HC edges after that accepting edge.
  int          m_edge = 0;
  bit          m_load, m_run, m_err;
  int          m_len, m_cnt, m_rel;
  bit          e_we;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_data;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_load = 0; m_run = 0; m_err = 0;
      m_len = 0; m_cnt = 0; m_rel = -1;
      e_we = 0; e_addr = '0; e_data = '0;
    end else begin
      m_edge++;
      e_we = 0;
      if (m_load) begin
        if (s_valid) begin
          e_we   = 1;
          e_addr = m_cnt[AW-1:0];
          e_data = s_data;
          m_cnt++;
          if (m_cnt == m_len) begin
            m_load = 0;
            m_rel  = m_edge + HC;
          end
        end
      end else if (m_rel >= 0) begin
        if (m_edge == m_rel) begin
          m_rel = -1;
          m_run = 1;
        end
      end else if (start) begin
        if (int'(prog_len) >= 1 && int'(prog_len) <= (1 << AW)) begin
          m_load = 1; m_len = int'(prog_len);
          m_cnt = 0; m_err = 0; m_run = 0;
        end else begin
          m_err = 1;
        end
      end
    end
  end

  logic [DW-1:0] mem [1 << AW];
  int  last_we_edge = 0;
  int  rise_edge = 0;
  int  last_addr = 0;
  bit  prev_cr = 0;

  always @(negedge clk) begin
    chk("s_ready", 32'(s_ready), 32'(m_load));
    chk("busy", 32'(busy), 32'(m_load || m_rel >= 0));
    chk("cpu_reset", 32'(cpu_reset), 32'(m_run));
    chk("done", 32'(done), 32'(m_run));
    chk("err", 32'(err), 32'(m_err));
    chk("word_cnt", 32'(word_cnt), 32'(m_cnt));
    chk("imem_we", 32'(imem_we), 32'(e_we));
    if (e_we) begin
      chk("imem_addr", 32'(imem_addr), 32'(e_addr));
      chk("imem_wdata", imem_wdata, e_data);
    end
    if (imem_we) begin
      mem[imem_addr] = imem_wdata;
      last_we_edge = m_edge;
      last_addr = int'(imem_addr);
    end
    if (!prev_cr && cpu_reset) rise_edge = m_edge;
    prev_cr = cpu_reset;
  end

  logic [DW-1:0] src [1 << AW];

  task automatic go(input int len);
    @(posedge clk); #1;
    start = 1; prog_len = (AW+1)'(len);
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic send(input int n, input int gapped);
    int i = 0;
    int c = 0;
    while (i < n && c < 600) begin
      s_data  = src[i];
      s_valid = !gapped || (c % 4 == 0) || (c % 4 == 3);
      @(negedge clk);
      if (s_valid && s_ready) i++;
      @(posedge clk); #1;
      c++;
    end
    s_valid = 0;
    if (i < n) chk("send_timeout", 32'(i), 32'(n));
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    #1;
    chk("done_wait", 32'(done), 32'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd0);
    chk({tag, "_imem_we"}, 32'(imem_we), 32'd0);
    chk({tag, "_imem_addr"}, 32'(imem_addr), 32'd0);
    chk({tag, "_imem_wdata"}, imem_wdata, 32'd0);
    chk({tag, "_s_ready"}, 32'(s_ready), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_word_cnt"}, 32'(word_cnt), 32'd0);
  endtask

  logic [DW-1:0] prog14 [14] = '{
    32'h20010000, 32'h20020005, 32'h20030001, 32'h00221820,
    32'hac030000, 32'h8c040000, 32'h10400003, 32'h00000000,
    32'h2042ffff, 32'h00832020, 32'h1000fffc, 32'h00000000,
    32'hac040004, 32'h08000001
  };

  initial begin
    reset = 0; start = 0; prog_len = '0;
    s_valid = 0; s_data = '0;
    #12;
    check_reset_vals("por");
    chk("por_err", 32'(err), 32'd0);
    @(negedge clk); reset = 1;

    for (int i = 0; i < 14; i++) src[i] = prog14[i];
    go(14);
    send(14, 0);
    wait_done();
    chk("l1_word_cnt", 32'(word_cnt), 32'd14);
    chk("l1_release", 32'(rise_edge - last_we_edge), 32'd4);
    chk("l1_mem0", mem[0], 32'h20010000);
    chk("l1_mem13", mem[13], 32'h08000001);

    for (int i = 0; i < 14; i++) mem[i] = '0;
    go(14);
    chk("run_restart_cpu_reset", 32'(cpu_reset), 32'd0);
    send(14, 1);
    wait_done();
    chk("l2_release", 32'(rise_edge - last_we_edge), 32'd4);
    for (int i = 0; i < 14; i++) chk("l2_mem", mem[i], prog14[i]);

    @(negedge clk); reset = 0;
    @(negedge clk); reset = 1;
    go(0);
    chk("len0_err", 32'(err), 32'd1);
    go(65);
    chk("len65_err", 32'(err), 32'd1);
    chk("len65_busy", 32'(busy), 32'd0);
    chk("len65_cpu_reset", 32'(cpu_reset), 32'd0);
    for (int i = 0; i < 3; i++) src[i] = 32'h11110000 + 32'(i);
    go(3);
    chk("len3_err_clr", 32'(err), 32'd0);
    send(3, 0);
    wait_done();
    chk("len3_mem2", mem[2], 32'h11110002);

    for (int i = 0; i < 64; i++) src[i] = 32'hA5000000 + 32'(i);
    go(64);
    send(64, 0);
    wait_done();
    chk("l64_last_addr", 32'(last_addr), 32'd63);
    chk("l64_mem63", mem[63], 32'hA500003F);
    chk("l64_mem0", mem[0], 32'hA5000000);
    chk("l64_word_cnt", 32'(word_cnt), 32'd64);

    for (int i = 0; i < 5; i++) src[i] = 32'h55550000 + 32'(i);
    go(14);
    send(5, 0);
    #2 reset = 0;
    #1 check_reset_vals("async");
    @(negedge clk); @(negedge clk); reset = 1;
    src[0] = 32'hCAFE0000; src[1] = 32'hCAFE0001;
    go(2);
    send(2, 0);
    wait_done();
    chk("rl_mem0", mem[0], 32'hCAFE0000);
    chk("rl_mem1", mem[1], 32'hCAFE0001);

    src[0] = 32'hBEEF0000; src[1] = 32'hBEEF0001;
    go(2);
    chk("run2_cpu_reset", 32'(cpu_reset), 32'd0);
    chk("run2_busy", 32'(busy), 32'd1);
    send(2, 0);
    wait_done();
    chk("run2_release", 32'(rise_edge - last_we_edge), 32'd4);
    chk("run2_mem1", mem[1], 32'hBEEF0001);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Boot-time program loader for the single-cycle MIPS core. It accepts instruction words over a valid/ready stream and writes them sequentially into instruction memory from address 0. The CPU is held in reset throughout the load and released a fixed number of cycles after the last write. It is the writer side of the instruction-memory/CPU-reset interface that the core and its top-level benches consume.

Parameters:
ADDR_WIDTH, 6, instruction-memory word-address width; depth = 2^ADDR_WIDTH words.
DATA_WIDTH, 32, instruction word width.
HOLD_CYCLES, 4, cycles the CPU stays in reset after the last beat is accepted; legal range 1..255.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset.
start  in  1  single-cycle request to begin a load.
prog_len  in  ADDR_WIDTH+1  number of words to load; sampled on start.
s_valid  in  1  stream word valid.
s_ready  out  1  loader accepts a word this cycle.
s_data  in  DATA_WIDTH  stream instruction word.
imem_we  out  1  instruction-memory write enable.
imem_addr  out  ADDR_WIDTH  word address (word index, not byte address).
imem_wdata  out  DATA_WIDTH  write data.
cpu_reset  out  1  active-low reset to the core; 0 holds the CPU.
busy  out  1  high in LOAD and HOLD.
done  out  1  high in RUN.
err  out  1  sticky flag for an illegal prog_len.
word_cnt  out  ADDR_WIDTH+1  beats accepted in the current load.

Behaviour:
- Reset (async, reset=0) forces state IDLE and sets outputs: cpu_reset=0, imem_we=0, imem_addr=0, imem_wdata=0, s_ready=0, busy=0, done=0, err=0, word_cnt=0. Internal length and hold counters are cleared.
- States: IDLE, LOAD, HOLD, RUN. All outputs are registered except s_ready, which is defined as (state==LOAD).
- IDLE:
  - start with 1 <= prog_len <= 2^ADDR_WIDTH: latch prog_len, set word_cnt=0, err=0, busy=1, go to LOAD.
  - start with prog_len==0 or prog_len > 2^ADDR_WIDTH: set err=1, stay in IDLE.
- LOAD:
  - A beat is accepted on a rising edge where s_valid && s_ready.
  - On the accepting edge, register imem_we=1, imem_addr=word_cnt[ADDR_WIDTH-1:0], imem_wdata=s_data, then increment word_cnt. The memory write therefore occurs on the following edge.
  - imem_we is 0 in any cycle without an accepted beat.
  - s_valid gaps of any length are legal; nothing is dropped or duplicated.
  - When the accepted beat makes word_cnt==prog_len, go to HOLD on that same edge. s_ready is 0 from the next cycle.
  - start is ignored in LOAD.
- HOLD:
  - cpu_reset stays 0 and the hold counter counts HOLD_CYCLES cycles.
  - On the edge ending the last hold cycle: cpu_reset=1, busy=0, done=1, go to RUN.
  - If the last beat is accepted at edge k, cpu_reset rises at edge k+HOLD_CYCLES.
  - start is ignored in HOLD.
- RUN:
  - cpu_reset=1 and done=1; the core fetches from address 0 (PC 0x00).
  - A legal start drives cpu_reset=0, done=0, busy=1 on the next edge, resets word_cnt to 0, and goes to LOAD.
  - An illegal start sets err=1 and stays in RUN; the CPU keeps running.
- word_cnt holds its final value in HOLD and RUN until the next legal start.
- prog_len = 2^ADDR_WIDTH fills the whole memory. imem_addr must not wrap within one load; the last address is 2^ADDR_WIDTH-1.
- Reset asserted mid-load: immediate return to reset values with the CPU held. Partially written memory contents are undefined for the design; a new start is required.

Test Plan:
- Load 14 words (0x20010000..0x08000001, covering the program at PC 0x00-0x34), s_valid continuous -> imem_we pulses at addr 0..13 with matching data; s_ready low after beat 14; cpu_reset rises exactly 4 cycles after beat-14 acceptance; done=1, word_cnt=14.
- Same load with s_valid toggled 1-0-0-1 -> same 14 writes in order, no extra imem_we, release timing still relative to the last accept.
- start with prog_len=0, then prog_len=65 at ADDR_WIDTH=6 -> err=1, state stays IDLE, cpu_reset=0, no writes; next start with prog_len=3 clears err.
- prog_len=64 -> writes to addr 0..63, no wrap; done=1.
- reset=0 after 5 accepted beats -> all outputs return to reset values asynchronously; after release, start/prog_len=2 reloads from addr 0.
- In RUN, start/prog_len=2 -> cpu_reset=0 on the next edge, two writes at addr 0 and 1, then release after HOLD_CYCLES.
